// File: rtl/ntt_cmd_dispatcher.sv
// ntt_cmd_dispatcher
//   In-order command queue between the host command stream and an array of
//   NUM_ENG ntt_engine instances. Host commands are buffered in a FIFO; the
//   head command is issued to its target engine once that engine is ready and
//   has no command outstanding. Opcode 8'hFF is a FENCE: it waits until every
//   engine is idle and is then retired without being issued.
//
// Handshakes:
//   host side  : a command transfers on a clk edge where host_valid && host_ready.
//                host_ready is !full and is combinational.
//   engine side: eng_cmd_valid[e] is a one-cycle issue strobe; the shared bus
//                (eng_cmd_opcode/slot/dma_addr) is valid with it and then holds.
//                After an issue the engine is considered pending until it is
//                seen with eng_ready low; only then may it receive another
//                command.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   host_valid/ready    host command handshake
//   host_opcode/slot/dma_addr/eng  host command fields
//   eng_cmd_valid       one-hot issue strobe, one bit per engine
//   eng_cmd_opcode/slot/dma_addr   shared command bus to the engines
//   eng_ready           per-engine ready
//   q_level             FIFO occupancy
//   all_idle            FIFO empty, nothing pending, all engines ready
//   issued_count        issued commands (fences excluded), wraps
//   err_bad_eng         sticky: a command targeting a missing engine was dropped
//   dbg_state           current FSM state (S_IDLE=0, S_DISPATCH=1, S_FENCE=2)
//
// Optional feature (define CMD_DISPATCH_STATS_EN):
//   stall_cycles        cycles a valid non-fence head could not issue (saturating)
//   fence_count         fences retired (saturating)

module ntt_cmd_dispatcher #(
    parameter int NUM_ENG    = 4,
    parameter int ENG_W      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [7:0]           host_opcode,
    input  logic [3:0]           host_slot,
    input  logic [47:0]          host_dma_addr,
    input  logic [ENG_W-1:0]     host_eng,
    output logic [NUM_ENG-1:0]   eng_cmd_valid,
    output logic [7:0]           eng_cmd_opcode,
    output logic [3:0]           eng_cmd_slot,
    output logic [47:0]          eng_cmd_dma_addr,
    input  logic [NUM_ENG-1:0]   eng_ready,
    output logic [FIFO_AW:0]     q_level,
    output logic                 all_idle,
    output logic [31:0]          issued_count,
    output logic                 err_bad_eng,
`ifdef CMD_DISPATCH_STATS_EN
    output logic [31:0]          stall_cycles,
    output logic [15:0]          fence_count,
`endif
    output logic [1:0]           dbg_state
);

    localparam int          ENT_W     = 8 + 4 + 48 + ENG_W;
    localparam logic [7:0]  OP_FENCE  = 8'hFF;
    localparam logic [31:0] NUM_ENG_U = 32'(NUM_ENG);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] ONE_CNT   = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_FENCE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ---------------- command FIFO ----------------
    logic [ENT_W-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign host_ready = !fifo_full;
    assign push       = host_valid && host_ready;
    assign q_level    = count;

    logic [7:0]       head_opcode;
    logic [3:0]       head_slot;
    logic [47:0]      head_addr;
    logic [ENG_W-1:0] head_eng;
    logic [31:0]      head_eng_ext;
    logic             head_bad;

    assign {head_opcode, head_slot, head_addr, head_eng} = mem[rd_ptr];
    assign head_eng_ext = 32'(head_eng);
    assign head_bad     = (head_eng_ext >= NUM_ENG_U);

    // One-hot decode of the head's target; all zero for an out-of-range index.
    logic [NUM_ENG-1:0] eng_sel;
    always_comb begin
        eng_sel = '0;
        for (int e = 0; e < NUM_ENG; e++) begin
            if (head_eng_ext == unsigned'(e)) eng_sel[e] = 1'b1;
        end
    end

    logic [NUM_ENG-1:0] pend;
    logic               can_issue, issue, drop_bad, last_entry;

    assign can_issue  = |(eng_sel & eng_ready & ~pend);
    // The pop in progress empties the FIFO (no refill on the same edge).
    assign last_entry = (count == ONE_CNT) && !push;
    assign all_idle   = fifo_empty && (pend == '0) && (&eng_ready);
    assign dbg_state  = state_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        issue    = 1'b0;
        drop_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else if (head_opcode == OP_FENCE) begin
                    state_d = S_FENCE;
                end else if (head_bad) begin
                    pop      = 1'b1;
                    drop_bad = 1'b1;
                    if (last_entry) state_d = S_IDLE;
                end else if (can_issue) begin
                    pop   = 1'b1;
                    issue = 1'b1;
                    if (last_entry) state_d = S_IDLE;
                end
            end
            S_FENCE: begin
                if (!fifo_empty && (pend == '0) && (&eng_ready)) begin
                    pop     = 1'b1;
                    state_d = last_entry ? S_IDLE : S_DISPATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {host_opcode, host_slot, host_dma_addr, host_eng};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // ---------------- issue datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend             <= '0;
            eng_cmd_valid    <= '0;
            eng_cmd_opcode   <= '0;
            eng_cmd_slot     <= '0;
            eng_cmd_dma_addr <= '0;
            issued_count     <= '0;
            err_bad_eng      <= 1'b0;
        end else begin
            // Pending clears once the engine is seen busy; issue sets it.
            pend          <= (pend & eng_ready) | (issue ? eng_sel : '0);
            eng_cmd_valid <= issue ? eng_sel : '0;
            if (issue) begin
                eng_cmd_opcode   <= head_opcode;
                eng_cmd_slot     <= head_slot;
                eng_cmd_dma_addr <= head_addr;
                issued_count     <= issued_count + 32'd1;
            end
            if (drop_bad) err_bad_eng <= 1'b1;
        end
    end

`ifdef CMD_DISPATCH_STATS_EN
    logic stall, fence_done;
    assign stall = (state_q == S_DISPATCH) && !fifo_empty && (head_opcode != OP_FENCE)
                   && !head_bad && !can_issue;
    assign fence_done = (state_q == S_FENCE) && pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fence_count  <= '0;
        end else begin
            if (stall && (stall_cycles != '1))     stall_cycles <= stall_cycles + 32'd1;
            if (fence_done && (fence_count != '1)) fence_count  <= fence_count + 16'd1;
        end
    end
`endif

endmodule
